// File: rtl/button_pkg.sv
// Shared types for the button gesture decoder: event codes and FSM states.
package button_pkg;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned CODE_W = 3;

    typedef enum logic [CODE_W-1:0] {
        EV_NONE         = 3'd0,
        EV_SHORT        = 3'd1,
        EV_DOUBLE       = 3'd2,
        EV_LONG_START   = 3'd3,
        EV_REPEAT       = 3'd4,
        EV_LONG_RELEASE = 3'd5
    } event_code_t;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        LONG,
        WAIT_REL
    } btn_state_t;

endpackage

// File: rtl/button_event_reg.sv
// Held valid/code register with ack handshake and a sticky overflow flag.
// It is reusable by any event source that pulses load for one cycle.
module button_event_reg
    import button_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  event_code_t load_code,
    input  logic        ack,
    output logic        valid,
    output event_code_t code,
    output logic        overflow
);

    // An ack only counts while an event is pending. A load alongside an
    // accepted ack replaces the event; a load while pending and unacked is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            code     <= EV_NONE;
            overflow <= 1'b0;
        end else if (load) begin
            if (!valid || ack) begin
                valid    <= 1'b1;
                code     <= load_code;
                overflow <= 1'b0;
            end else begin
                overflow <= 1'b1;
            end
        end else if (valid && ack) begin
            valid    <= 1'b0;
            code     <= EV_NONE;
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into short, double, long-start,
// repeat and long-release gesture events, presented through a held valid/ack register.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES       = 32'd50000000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 32'd15000000,
    parameter int unsigned REPEAT_CYCLES     = 32'd10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_level,
    output logic       event_valid,
    output logic [2:0] event_code,
    input  logic       event_ack,
    output logic       overflow,
    output logic       pressed
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DOUBLE_GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             btn_q;
    logic             rise_c, fall_c;
    logic             emit_c;
    event_code_t      emit_code_c;
    event_code_t      ev_code;

    assign rise_c  = button_level & ~btn_q;
    assign fall_c  = ~button_level & btn_q;
    assign pressed = btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            btn_q <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            btn_q <= button_level;
        end
    end

    // Every compare that fires clears the counter, so it never wraps.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        emit_c      = 1'b0;
        emit_code_c = EV_NONE;
        case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nxt = PRESS1;
                    count_nxt = '0;
                end
            end
            PRESS1: begin
                if (fall_c) begin
                    state_nxt = GAP;
                    count_nxt = '0;
                end else if (count == LONG_LAST) begin
                    emit_c      = 1'b1;
                    emit_code_c = EV_LONG_START;
                    state_nxt   = LONG;
                    count_nxt   = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            GAP: begin
                if (rise_c) begin
                    emit_c      = 1'b1;
                    emit_code_c = EV_DOUBLE;
                    state_nxt   = WAIT_REL;
                    count_nxt   = '0;
                end else if (count == GAP_LAST) begin
                    emit_c      = 1'b1;
                    emit_code_c = EV_SHORT;
                    state_nxt   = IDLE;
                    count_nxt   = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            LONG: begin
                // Release wins over a repeat falling due in the same cycle.
                if (fall_c) begin
                    emit_c      = 1'b1;
                    emit_code_c = EV_LONG_RELEASE;
                    state_nxt   = IDLE;
                    count_nxt   = '0;
                end else if (count == REPEAT_LAST) begin
                    emit_c      = 1'b1;
                    emit_code_c = EV_REPEAT;
                    count_nxt   = '0;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (fall_c) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    button_event_reg u_event_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (emit_c),
        .load_code (emit_code_c),
        .ack       (event_ack),
        .valid     (event_valid),
        .code      (ev_code),
        .overflow  (overflow)
    );

    assign event_code = ev_code;

endmodule
